// File: rtl/fetch_stage_pkg.sv
// Pipe_Buf_Reg_PKG: shared IF/ID register layout, fetch FSM states and pc constants
package Pipe_Buf_Reg_PKG;

    localparam logic [8:0] PC_STEP = 9'd4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_e;

    typedef struct packed {
        logic [8:0]  Curr_Pc;
        logic [31:0] Curr_Instr;
    } if_id_reg;

    // Fetch addresses are word aligned; the low two target bits are dropped
    function automatic logic [8:0] align_pc(input logic [8:0] a);
        return {a[8:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus between fetch and imem
interface fetch_stage_if;

    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_rvalid, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_rvalid, output imem_rdata);

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// fetch_pc_reg: program counter with +4 increment and aligned redirect load
module fetch_pc_reg
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter logic [8:0] RESET_PC = 9'h000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       redirect,
    input  logic [8:0] redirect_pc,
    output logic [8:0] pc
);

    // Redirect wins over increment; the 9-bit add wraps silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc <= RESET_PC;
        else if (redirect)
            pc <= align_pc(redirect_pc);
        else if (inc)
            pc <= pc + PC_STEP;
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage, one outstanding imem request, stall hold buffer, redirect kill.
// Defining FETCH_PERF_CNT_EN adds the stall_cycles and flush_count counter outputs.
module fetch_stage
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter logic [8:0] RESET_PC = 9'h000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          redirect,
    input  logic [8:0]    redirect_pc,
    fetch_stage_if.master imem,
    output if_id_reg      if_id,
    output logic          if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cycles,
    output logic [31:0]   flush_count
`endif
);

    fetch_state_e state, state_nx;
    logic         kill, kill_nx;
    logic         take, deliver_wait, deliver_hold;
    logic [8:0]   pc;
    if_id_reg     hold_buf;

    // A response is accepted only if no redirect killed it earlier or in the same cycle
    assign take         = state == WAIT && imem.imem_rvalid && !kill && !redirect;
    assign deliver_wait = take && !stall;
    assign deliver_hold = state == HOLD && !stall && !redirect;
    assign imem.imem_addr = pc;

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk         (clk),
        .reset       (reset),
        .inc         (take),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc)
    );

    // Next state, kill tracking and the request strobe
    always_comb begin
        state_nx      = state;
        kill_nx       = kill;
        imem.imem_req = 1'b0;
        case (state)
            IDLE: state_nx = REQ;
            REQ: begin
                imem.imem_req = 1'b1;
                state_nx      = WAIT;
                kill_nx       = redirect;
            end
            WAIT: begin
                state_nx = !imem.imem_rvalid ? WAIT : (take && stall) ? HOLD : REQ;
                kill_nx  = !imem.imem_rvalid && (kill || redirect);
            end
            HOLD: state_nx = (redirect || !stall) ? REQ : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    // State, kill flag and the buffer that parks a response arriving under stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            kill     <= 1'b0;
            hold_buf <= '0;
        end else begin
            state <= state_nx;
            kill  <= kill_nx;
            if (redirect)
                hold_buf <= '0;
            else if (take && stall)
                hold_buf <= if_id_reg'{Curr_Pc: pc, Curr_Instr: imem.imem_rdata};
        end
    end

    // IF/ID register: redirect squashes, stall freezes, otherwise bubble unless something lands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id       <= '0;
            if_id_valid <= 1'b0;
        end else if (redirect) begin
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_valid <= deliver_wait || deliver_hold;
            if (deliver_hold)
                if_id <= hold_buf;
            else if (deliver_wait)
                if_id <= if_id_reg'{Curr_Pc: pc, Curr_Instr: imem.imem_rdata};
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Wrapping counters of decode-blocked cycles and redirect pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall && if_id_valid)
                stall_cycles <= stall_cycles + 32'd1;
            if (redirect)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench with a behavioural imem and fetch-stream model
module tb_fetch_stage;
    import Pipe_Buf_Reg_PKG::*;

    localparam logic [8:0] RST_PC = 9'h000;

    logic       clk = 1'b0;
    logic       reset, stall, redirect;
    logic [8:0] redirect_pc;
    if_id_reg   if_id;
    logic       if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    fetch_stage_if imem();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .if_id       (if_id),
        .if_id_valid (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] addr;
        int         lat;
        bit         killed;
    } pend_t;

    pend_t      pend[$];
    if_id_reg   sb[$];
    logic [8:0] exp_fetch = RST_PC;
    bit         m_rst = 1'b1, m_stall = 1'b0, m_redir = 1'b0;
    int         lat_lo = 0, lat_hi = 0;
    int         n_chk = 0, n_pass = 0, n_deliv = 0;
    logic       prev_valid = 1'b0;
    if_id_reg   prev_if_id = '0;

    function automatic logic [31:0] word_at(input logic [8:0] a);
        return {7'h00, a, 16'h0013};
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Memory and program-order model: sees each cycle's inputs, predicts what decode must receive
    initial begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            m_rst   = !reset;
            m_stall = stall;
            m_redir = redirect;
            if (!reset) begin
                foreach (pend[i]) begin
                    pend[i].killed = 1'b1;
                    pend[i].lat    = 0;
                end
                sb.delete();
                exp_fetch = RST_PC;
            end else begin
                if (imem.imem_rvalid && pend.size() != 0) begin
                    if (!pend[0].killed && !redirect)
                        sb.push_back(if_id_reg'{Curr_Pc: pend[0].addr, Curr_Instr: word_at(pend[0].addr)});
                    void'(pend.pop_front());
                end
                if (imem.imem_req) begin
                    check("req_addr", 64'(imem.imem_addr), 64'(exp_fetch));
                    check("one_outstanding", 64'(pend.size() + sb.size()), 64'd0);
                    pend.push_back('{imem.imem_addr, int'($urandom_range(lat_hi, lat_lo)), 1'b0});
                    exp_fetch = imem.imem_addr + 9'd4;
                end
                if (redirect) begin
                    foreach (pend[i]) pend[i].killed = 1'b1;
                    sb.delete();
                    exp_fetch = {redirect_pc[8:2], 2'b00};
                end
            end
            @(posedge clk);
            #1;
            if (!m_rst && pend.size() != 0 && pend[0].lat == 0) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = word_at(pend[0].addr);
            end else begin
                imem.imem_rvalid = 1'b0;
                if (!m_rst && pend.size() != 0) pend[0].lat--;
            end
        end
    end

    // Monitor: compares the IF/ID register after every edge against the scoreboard
    always @(negedge clk) begin
        if (!reset || m_rst) begin
            check("reset_valid", 64'(if_id_valid), 64'd0);
            check("reset_if_id", 64'(if_id), 64'd0);
            check("reset_req", 64'(imem.imem_req), 64'd0);
        end else if (m_redir) begin
            check("redirect_bubble", 64'(if_id_valid), 64'd0);
        end else if (m_stall) begin
            check("stall_valid", 64'(if_id_valid), 64'(prev_valid));
            check("stall_if_id", 64'(if_id), 64'(prev_if_id));
        end else if (sb.size() != 0) begin
            check("deliver_valid", 64'(if_id_valid), 64'd1);
            check("deliver_if_id", 64'(if_id), 64'(sb[0]));
            void'(sb.pop_front());
            n_deliv++;
        end else begin
            check("bubble_valid", 64'(if_id_valid), 64'd0);
        end
        prev_valid = if_id_valid;
        prev_if_id = if_id;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input bit any, input logic [8:0] a);
        for (int i = 0; i < 400; i++) begin
            if (imem.imem_req && (any || imem.imem_addr == a)) return;
            step();
        end
        n_chk++;
        $display("FAIL wait_req: no request for %0h within 400 cycles", a);
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        repeat (3) step();
        reset = 1'b1;
        // Back-to-back fetches with one-cycle memory latency, then a 3-cycle stall at 0x010
        wait_req(1'b0, 9'h010);
        step();
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        // Redirect to an unaligned target while the 0x020 response is still outstanding
        lat_lo = 2;
        lat_hi = 2;
        wait_req(1'b0, 9'h020);
        step();
        redirect    = 1'b1;
        redirect_pc = 9'h083;
        step();
        redirect = 1'b0;
        repeat (12) step();
        // Wrap from 0x1FC to 0x000
        lat_lo = 0;
        lat_hi = 1;
        redirect    = 1'b1;
        redirect_pc = 9'h1F4;
        step();
        redirect = 1'b0;
        repeat (16) step();
        // Redirect while stalled in HOLD
        lat_hi = 0;
        stall  = 1'b1;
        repeat (4) step();
        redirect    = 1'b1;
        redirect_pc = 9'h044;
        step();
        redirect = 1'b0;
        step();
        stall = 1'b0;
        repeat (8) step();
        // Reset while waiting; the stale response shows up after release
        lat_lo = 3;
        lat_hi = 3;
        wait_req(1'b1, 9'h000);
        step();
        reset = 1'b0;
        repeat (2) step();
        reset  = 1'b1;
        lat_lo = 0;
        lat_hi = 0;
        repeat (10) step();
        // Random traffic
        lat_hi = 3;
        for (int i = 0; i < 2000; i++) begin
            stall       = ($urandom % 4) == 0;
            redirect    = ($urandom % 20) == 0;
            redirect_pc = 9'($urandom);
            reset       = ($urandom % 600) != 0;
            step();
        end
        reset    = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        repeat (10) step();
        check("deliveries", 64'(n_deliv >= 100), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 9'h000, shall be the first fetch address after reset.
REQ-002 Port clk  input  1  shall be the single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  shall be the asynchronous, active-low reset.
REQ-004 Port stall  input  1  shall be the hazard-unit hold: IF/ID output frozen while high.
REQ-005 Port redirect  input  1  shall be the taken branch/jump from EX, one-cycle pulse.
REQ-006 Port redirect_pc  input  9  shall be the target byte address for redirect.
REQ-007 Port imem_req  output  1  shall be the instruction-memory request strobe, one cycle per fetch.
REQ-008 Port imem_addr  output  9  shall be the fetch byte address, valid while imem_req is high.
REQ-009 Port imem_rvalid  input  1  shall mark imem_rdata valid; response latency 1..N cycles, in order.
REQ-010 Port imem_rdata  input  32  shall be the returned instruction word.
REQ-011 Port if_id  output  if_id_reg  shall be the registered {Curr_Pc, Curr_Instr} fed to decode.
REQ-012 Port if_id_valid  output  1  shall mark if_id as a real instruction (0 = bubble).

Function
REQ-013 FSM states IDLE, REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-014 IDLE -> REQ unconditionally on the first clock edge after reset deasserts.
REQ-015 REQ: imem_req=1, imem_addr=pc for exactly one cycle; next state WAIT.
REQ-016 WAIT: hold until imem_rvalid; on rvalid with kill=0 and stall=0, load if_id={pc, imem_rdata}, if_id_valid=1, pc<=pc+4, next REQ.
REQ-017 WAIT with rvalid, kill=0, stall=1: capture {pc, rdata} in hold buffer, pc<=pc+4, next HOLD; if_id unchanged.
REQ-018 HOLD: when stall=0, move hold buffer to if_id, if_id_valid=1, next REQ.
REQ-019 stall=0 and no instruction delivered that cycle: if_id_valid<=0; if_id contents don't-care.
REQ-020 stall=1 without redirect: if_id and if_id_valid shall not change.
REQ-021 Redirect priority over stall: next cycle if_id_valid=0, pc<={redirect_pc[8:2],2'b00}, hold buffer discarded.
REQ-022 Redirect in REQ or WAIT: set kill; the outstanding response is dropped on arrival, clears kill, next REQ at new pc.
REQ-023 Redirect in HOLD or IDLE: next state REQ at new pc.
REQ-024 Redirect in the same cycle as rvalid: the response is dropped, never reaches if_id.
REQ-025 pc arithmetic is 9-bit modulo: 9'h1FC + 4 = 9'h000, no flag.
REQ-026 Latency: rvalid at edge N -> if_id_valid high after edge N (unstalled).

Reset
REQ-027 Asserted reset: state=IDLE, pc=RESET_PC, kill=0, imem_req=0, if_id_valid=0, if_id=0, hold buffer=0, counters=0.
REQ-028 Reset mid-request: outstanding response after release is ignored (IDLE/REQ ignore rvalid).

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: add outputs stall_cycles[31:0] (cycles with stall=1 and if_id_valid=1) and flush_count[31:0] (redirect pulses), both wrapping.
REQ-030 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-031 if_id_reg and a fetch_state_e enum {IDLE,REQ,WAIT,HOLD} shall live in Pipe_Buf_Reg_PKG.
REQ-032 PC_STEP=9'd4 constant in the same package.
REQ-033 One sub-module fetch_pc_reg (pc register, increment, redirect mux) is natural; FSM and buffers stay in fetch_stage.

Verification
REQ-034 Reset release, rvalid 1 cycle after each req, rdata=32'h00000013 -> if_id.Curr_Pc 0x000,0x004,0x008 on consecutive deliveries, imem_addr matching.
REQ-035 stall high 3 cycles while rvalid arrives for pc 0x010 -> if_id unchanged 3 cycles, then Curr_Pc=0x010, valid=1; no imem_req during HOLD.
REQ-036 redirect to 9'h083 during WAIT at pc 0x020 -> response for 0x020 dropped, next imem_addr=0x080, if_id_valid=0 meanwhile.
REQ-037 pc at 0x1FC delivered -> next imem_addr=0x000.
REQ-038 redirect and stall together in HOLD -> if_id_valid=0 next cycle, hold discarded, next req at target.
REQ-039 reset asserted in WAIT, rvalid arrives after release -> ignored; first if_id Curr_Pc=RESET_PC.
